apb_slave_regbank: RTL
======================

# apb_slave_regbank

APB responder that sits on one `Pselx` line of the AHB-to-APB bridge and terminates its transfers. Decodes setup/access phases, returns read data, commits writes to a small word-addressed register bank and flags illegal accesses on `Pslverr`. Two read-only counters record completed reads and writes for bring-up and debug.

## Interface

Parameters:

- `SEL_IDX`, 0: which bit of `Pselx` selects this slave (0..2).
- `NUM_REGS`, 16: number of 32-bit word registers, power of two, 4..256.
- `ID_VALUE`, 32'h4150_4231: constant returned by register 0.
- `WAIT_CYCLES`, 2: access-phase wait states, 1..15. Used only when `APB_SLV_WAIT_EN` is defined.

Ports:

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Pselx`  in  3  slave selects from the bridge; only bit `SEL_IDX` is used.
- `Penable`  in  1  APB access phase.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  32  byte address; word index = `Paddr[log2(NUM_REGS)+1:2]`.
- `Pwdata`  in  32  write data.
- `Prdata`  out  32  read data; registered.
- `Pready`  out  1  transfer completes in the current access cycle.
- `Pslverr`  out  1  error response; valid only when `Pready`=1.

## Operation

- Register map, by word index:
  - 0: ID, read-only, `ID_VALUE`.
  - 1: WR_CNT, read-only, count of completed error-free writes.
  - 2: RD_CNT, read-only, count of completed error-free reads.
  - 3..NUM_REGS-1: read/write scratch, reset value 0.
- Error conditions, evaluated in the setup cycle:
  - `Paddr[1:0]` != 0.
  - Any `Paddr` bit above the index field is set (out of range).
  - A write to index 0, 1 or 2.
- An error transfer returns `Pslverr`=1 and `Prdata`=0. No register or counter changes.
- FSM states:
  - IDLE → SETUP when `sel` (= `Pselx[SEL_IDX]`) is 1 and `Penable` is 0. Read data and the error flag are captured on this edge.
  - SETUP → ACCESS on the next edge if `sel` and `Penable` are both 1.
  - SETUP → IDLE otherwise (abort: no write, no count).
  - ACCESS → IDLE when `Pready`=1; the write commits and the counter increments on that edge.
  - ACCESS → IDLE if `sel` drops while `Pready` is still 0 (abort, no commit).
- `Penable`=1 with no preceding setup cycle: ignored. FSM stays IDLE, nothing is written.
- Back-to-back transfers, i.e. `sel` held and `Penable` low on the cycle after completion: re-enter SETUP directly, no idle cycle required.
- Counters are 32-bit and wrap from FFFF_FFFF to 0.
- A read of WR_CNT/RD_CNT returns the value before the current transfer is counted.

## Timing

- Reset values: `Prdata`=0, `Pready`=0, `Pslverr`=0, FSM=IDLE, counters=0, scratch=0.
- `rst` asserted mid-transfer: all state returns to its reset value on that edge; a pending write is discarded.
- Zero-wait (macro undefined):
  - T0: setup cycle.
  - T1: `Penable`=1; `Pready`=1, and `Prdata`/`Pslverr` are valid.
  - A write is visible to a read whose setup cycle is T2.
- `Pready` is 0 outside ACCESS.
- `Prdata` holds its value until the next setup capture.
- `Pslverr` is 0 whenever `Pready` is 0.

## Configuration

- `APB_SLV_WAIT_EN` defined:
  - ACCESS holds `Pready`=0 for `WAIT_CYCLES` cycles, then drives `Pready`=1 for one cycle.
  - Total transfer length is `WAIT_CYCLES`+2 cycles.
  - The wait counter clears on reset and on abort.
- Undefined: no wait counter is built; `Pready`=1 in the first ACCESS cycle.

## Structure

- Package `apb_slv_pkg`: FSM state enum (IDLE, SETUP, ACCESS), register index constants (`IDX_ID`, `IDX_WR_CNT`, `IDX_RD_CNT`, `IDX_SCRATCH0`), default `ID_VALUE`.
- One sub-module, `apb_wait_gen`: loadable down-counter producing `Pready`. Instantiated only under `APB_SLV_WAIT_EN`.
- Decode, register bank and counters stay in the top.

## Test plan

- Reset, then read index 0 (`Paddr`=0x0) → `Prdata`=0x4150_4231, `Pslverr`=0, `Pready` asserted in the access cycle (cycle 2 with the macro off).
- Write 0xDEAD_BEEF to 0x0C, then read 0x0C back-to-back → read returns 0xDEAD_BEEF; WR_CNT=1, RD_CNT=1.
- Write to 0x04 (WR_CNT) and read 0x0D (misaligned) → `Pslverr`=1 on both, `Prdata`=0, WR_CNT unchanged.
- `NUM_REGS`=16, read 0x40 → `Pslverr`=1. Drive `Pselx` on a different bit → no response, `Pready` stays 0.
- Macro on, `WAIT_CYCLES`=3: write 0x1234 to 0x10 → `Pready` low 3 access cycles, high on the 4th. Drop `sel` after 1 wait cycle on a second write → register keeps 0x1234.
- Preload WR_CNT to FFFF_FFFF via forced state, do one write → WR_CNT=0. Assert `rst` during the setup cycle of a write to 0x14 → register 5 stays 0.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// Purpose: shared types and constants for the APB responder register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a; wait states are enabled by defining APB_SLV_WAIT_EN.
package apb_slv_pkg;

   // Responder phase tracking: SETUP is the first cycle after a captured
   // setup (the bus is expected to raise Penable), ACCESS covers any
   // further wait cycles.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int IDX_ID       = 0;
   localparam int IDX_WR_CNT   = 1;
   localparam int IDX_RD_CNT   = 2;
   localparam int IDX_SCRATCH0 = 3;

   localparam logic [31:0] ID_VALUE_DEF = 32'h4150_4231;

endpackage

// File: rtl/apb_wait_gen.sv
// Purpose: loadable down-counter that holds off Pready for a fixed number of access cycles.
// Latency: done rises WAIT_CYCLES counted access cycles after load.
// Backpressure: done low stalls the APB access phase; clr drops any count on abort.
module apb_wait_gen #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   input  logic clr,
   output logic done
);

   logic [3:0] cnt;

   // Load on setup capture, count down on each access cycle, clear on abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if (clr) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= WAIT_CYCLES[3:0];
      end else if (dec && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign done = (cnt == 4'd0);

endmodule

// File: rtl/apb_slave_regbank.sv
// Purpose: APB responder with ID, write/read counters and scratch registers; errors flagged on Pslverr.
// Latency: zero-wait by default (Pready in the first Penable cycle); APB_SLV_WAIT_EN adds WAIT_CYCLES waits.
// Backpressure: Pready low stretches the access phase; dropping sel mid-transfer aborts without side effects.
module apb_slave_regbank
   import apb_slv_pkg::*;
#(
   parameter int          SEL_IDX     = 0,
   parameter int          NUM_REGS    = 16,
   parameter logic [31:0] ID_VALUE    = ID_VALUE_DEF,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Pready,
   output logic        Pslverr
);

   localparam int IW = $clog2(NUM_REGS);

   apb_state_e  state_q, state_d;
   logic        sel;
   logic [IW-1:0] idx_in, idx_q;
   logic        err_in, err_q, wr_q;
   logic        setup_cap, acc_cyc, abort, wait_ok;
   logic [31:0] rd_mux;
   logic [31:0] wr_cnt, rd_cnt;
   logic [31:0] regs [NUM_REGS];

   assign sel    = Pselx[SEL_IDX];
   assign idx_in = Paddr[IW+1:2];

   // Misaligned, out-of-range, or a write aimed at a read-only register.
   assign err_in = (Paddr[1:0] != 2'b00)
                 | (|Paddr[31:IW+2])
                 | (Pwrite && (idx_in < IW'(IDX_SCRATCH0)));

   // Read mux evaluated in the setup cycle; counters give their pre-transfer value.
   always_comb begin
      rd_mux = regs[idx_in];
      if (idx_in == IW'(IDX_ID)) begin
         rd_mux = ID_VALUE;
      end else if (idx_in == IW'(IDX_WR_CNT)) begin
         rd_mux = wr_cnt;
      end else if (idx_in == IW'(IDX_RD_CNT)) begin
         rd_mux = rd_cnt;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: capture setup, complete on Pready, abort if the bus leaves the access phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sel && !Penable) state_d = SETUP;
         end
         SETUP, ACCESS: begin
            if (!(sel && Penable)) state_d = IDLE;
            else if (Pready)       state_d = IDLE;
            else                   state_d = ACCESS;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs and phase strobes; Penable with no captured setup is ignored in IDLE.
   always_comb begin
      setup_cap = (state_q == IDLE) && sel && !Penable;
      acc_cyc   = ((state_q == SETUP) || (state_q == ACCESS)) && sel && Penable;
      abort     = ((state_q == SETUP) || (state_q == ACCESS)) && !(sel && Penable);
      Pready    = acc_cyc && wait_ok;
      Pslverr   = Pready && err_q;
   end

`ifdef APB_SLV_WAIT_EN
   apb_wait_gen #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_gen (
      .clk  (clk),
      .rst  (rst),
      .load (setup_cap),
      .dec  (acc_cyc),
      .clr  (abort),
      .done (wait_ok)
   );
`else
   logic unused_wait_cfg;
   assign unused_wait_cfg = ^WAIT_CYCLES[3:0];
   assign wait_ok         = 1'b1;
`endif

   logic unused_sel_bits;
   assign unused_sel_bits = ^Pselx;

   // Setup capture of read data/error, and commit of writes and counts on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         Prdata <= 32'd0;
         err_q  <= 1'b0;
         wr_q   <= 1'b0;
         idx_q  <= '0;
         wr_cnt <= 32'd0;
         rd_cnt <= 32'd0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= 32'd0;
         end
      end else begin
         if (setup_cap) begin
            Prdata <= err_in ? 32'd0 : rd_mux;
            err_q  <= err_in;
            wr_q   <= Pwrite;
            idx_q  <= idx_in;
         end
         if (Pready && !err_q) begin
            if (wr_q) begin
               regs[idx_q] <= Pwdata;
               wr_cnt      <= wr_cnt + 32'd1;
            end else begin
               rd_cnt      <= rd_cnt + 32'd1;
            end
         end
      end
   end

endmodule
